// File: rtl/stage_writeback_buffered_pkg.sv
// rtl/stage_writeback_buffered_pkg.sv - shared opcode bit indices and default constants for the writeback stage
package stage_writeback_buffered_pkg;

  localparam int OP_INC   = 0;
  localparam int OP_DEC   = 1;
  localparam int OP_LEFT  = 2;
  localparam int OP_RIGHT = 3;
  localparam int OP_OUT   = 4;
  localparam int OP_IN    = 5;
  localparam int OP_JZ    = 6;
  localparam int OP_JNZ   = 7;

  localparam int OPCODE_MSB = 7;

  localparam int DEFAULT_FIFO_DEPTH = 4;

endpackage

// File: rtl/stage_writeback_buffered_ext_out_fifo.sv
// rtl/stage_writeback_buffered_ext_out_fifo.sv - register-array FIFO with combinational head for EXT output bytes
module ext_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enq,
  input  logic [WIDTH-1:0]       enq_data,
  input  logic                   deq,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  // The extra MSB on each pointer distinguishes full from empty when indices match.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (deq) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem[wr_ptr[AW-1:0]] <= enq_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/stage_writeback_buffered.sv
// rtl/stage_writeback_buffered.sv - final CPU pipeline stage: DRAM commit plus FIFO-buffered EXT output
module stage_writeback_buffered
  import stage_writeback_buffered_pkg::*;
#(
  parameter int A_WIDTH    = 12,
  parameter int D_WIDTH    = 8,
  parameter int C_WIDTH    = 8,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int SYNC_IN    = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [A_WIDTH-1:0]          dp,
  output logic                        dce,
  output logic [A_WIDTH-1:0]          da,
  output logic [D_WIDTH-1:0]          dq,
  output logic [C_WIDTH-1:0]          cq,
  output logic                        cwre,
  input  logic                        cbsy,
  input  logic [D_WIDTH-1:0]          a_in,
  input  logic [OPCODE_MSB:0]         operation_in,
  input  logic                        ack_in,
  output logic                        ack,
  output logic [OPCODE_MSB:0]         operation,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        drained
);

  logic               is_d;
  logic               is_x;
  logic               is_in;
  logic               full;
  logic               empty;
  logic               deq;
  logic               enq;
  logic               full_stall;
  logic               sync_stall;
  logic               fire;
  logic [C_WIDTH-1:0] enq_data;

  assign is_d  = operation_in[OP_INC] | operation_in[OP_DEC] | operation_in[OP_IN];
  assign is_x  = operation_in[OP_OUT];
  assign is_in = operation_in[OP_IN];

  assign deq  = !empty && !cbsy;
  assign cwre = deq;

  // A full FIFO can still take a byte when its head leaves in the same cycle.
  assign full_stall = is_x && full && !deq;
  assign sync_stall = (SYNC_IN != 0) && is_in && !empty;
  assign fire       = ack_in && !(full_stall || sync_stall);
  assign ack        = fire;

  assign dce = is_d && fire;
  assign da  = dp;
  assign dq  = a_in;
  assign enq = is_x && fire;

  generate
    if (C_WIDTH <= D_WIDTH) begin : g_trunc
      assign enq_data = a_in[C_WIDTH-1:0];
    end else begin : g_zext
      assign enq_data = {{(C_WIDTH-D_WIDTH){1'b0}}, a_in};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      operation <= '0;
    end else if (fire) begin
      operation <= operation_in;
    end else if (ack_in) begin
      operation <= '0;
    end
  end

  ext_out_fifo #(
    .WIDTH (C_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .enq      (enq),
    .enq_data (enq_data),
    .deq      (deq),
    .head     (cq),
    .full     (full),
    .empty    (empty),
    .level    (fifo_level)
  );

  assign drained = empty;

endmodule

// File: doc/stage_writeback_buffered.md
Name: stage_writeback_buffered

Overview:
Final pipeline stage of the CPU core; parametrised successor to the unbuffered writeback stage. Commits DRAM writes for INC/DEC/IN directly. Queues OUT bytes in a FIFO_DEPTH-entry output FIFO, so a busy EXT channel stalls the pipeline only when the FIFO is full. Optional IN-synchronisation mode drains pending output before an IN commits, so prompts appear before input is consumed.

Parameters:
A_WIDTH, 12, data pointer / DRAM address width
D_WIDTH, 8, cell and accumulator width
C_WIDTH, 8, EXT channel data width; a_in is truncated or zero-extended to C_WIDTH
FIFO_DEPTH, 4, output FIFO entries; power of two, >= 2
SYNC_IN, 1, 1 = IN stalls until the output FIFO is empty; 0 = no ordering between IN and OUT

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
dp  in  A_WIDTH  current data pointer
dce  out  1  DRAM write enable
da  out  A_WIDTH  DRAM write address, equals dp
dq  out  D_WIDTH  DRAM write data, equals a_in
cq  out  C_WIDTH  EXT write data, driven from the FIFO head
cwre  out  1  EXT write strobe
cbsy  in  1  EXT busy
a_in  in  D_WIDTH  accumulator from the previous stage
operation_in  in  OPCODE_MSB+1  one-hot opcode from the previous stage
ack_in  in  1  global advance enable
ack  out  1  accept handshake to the previous stage
operation  out  OPCODE_MSB+1  registered committed opcode
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
drained  out  1  FIFO empty; used by the halt logic

Behaviour:
- Reset values: operation=0, FIFO empty, fifo_level=0, drained=1, cwre=0, dce=0. An in-flight FIFO entry is discarded; there is no partial EXT write.
- is_d = OP_INC|OP_DEC|OP_IN. is_x = OP_OUT. is_in = OP_IN.
- deq = !empty && !cbsy. cwre = deq. cq = head entry, combinational.
- full_stall = is_x && full && !deq. A full FIFO accepts the new entry in the same cycle as a dequeue.
- sync_stall = SYNC_IN && is_in && !empty.
- stall = full_stall | sync_stall.
- fire = ack_in && !stall. ack = fire.
- dce = is_d && fire. Unlike the previous stage, dce is never asserted for a stalled or unacknowledged op.
- enq = is_x && fire. Writes C_WIDTH bits of a_in at the tail.
- Minimum latency: OUT accepted in cycle N gives cwre in cycle N+1 when cbsy=0. There is no bypass.
- Simultaneous enq and deq: level is unchanged, and the pointers both advance.
- Pointers wrap modulo FIFO_DEPTH. Full and empty are derived from an extra pointer bit.
- Operation register:
  - fire: operation <= operation_in.
  - else if ack_in: operation <= 0 (bubble).
  - else: hold.
- The FIFO keeps draining while ack_in=0. EXT output is independent of pipeline advance.
- OUT order on EXT equals program order. DRAM writes may precede older OUTs still queued, except IN when SYNC_IN=1.
- Multiple one-hot bits set in operation_in is illegal input; behaviour is undefined.

Decomposition:
- Constants.v (shared): OP_* bit indices, OPCODE_MSB, and the default FIFO depth constant.
- Sub-module ext_out_fifo (WIDTH, DEPTH): synchronous FIFO with enq, deq, head, full, empty, level.
  - Registered pointers; storage is a register array, with no read latency on head.
  - The top-level holds the handshake and stall logic, with the FIFO instantiated once.

Test Plan:
- Reset mid-drain: 3 OUTs queued, cbsy=1, assert reset -> level=0, drained=1, cwre=0, operation=0 the next cycle; no stale byte emitted after cbsy drops.
- Burst with busy EXT: cbsy=1, OUT 0x41..0x44 then OUT 0x45 (FIFO_DEPTH=4) -> the first 4 are acked, the 5th stalls with ack=0 and operation=0. Release cbsy -> cq sequence 41,42,43,44,45 in order, one per cycle.
- Full plus dequeue same cycle: FIFO full, cbsy=0, OUT 0x55 -> ack=1, level stays 4, and 0x55 later appears last.
- SYNC_IN: 2 OUTs queued, cbsy=1, then IN with a_in=0x07 -> dce=0 and ack=0 until both bytes are written. dce=1 with dq=0x07 and da=dp in the cycle after the FIFO empties. Repeat with SYNC_IN=0 -> IN commits immediately.
- INC/DEC with ack_in=0: operation_in=INC -> dce=0 and operation holds its value. Raise ack_in -> dce=1 for exactly 1 cycle.
- Width rule, C_WIDTH=4: OUT with a_in=0xA7 -> cq=0x7. With C_WIDTH=12 and D_WIDTH=8: a_in=0xA7 -> cq=0x0A7.
